// File: rtl/bnr_cfg_pkg.sv
// Shared definitions for the 2DNR coefficient bank: legacy default tables,
// address-map helpers and the commit FSM state type.
package bnr_cfg_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } bnr_state_t;

    // Geometry of the legacy fixed tables.
    localparam int LEGACY_KSIZE = 7;
    localparam int LEGACY_PTS   = 9;

    // Legacy 7x7 spatial kernel, row-major, index r*7+c.
    localparam logic [4:0] LEGACY_WEIGHTS [49] = '{
        5'd28, 5'd29, 5'd29, 5'd30, 5'd29, 5'd29, 5'd28,
        5'd29, 5'd30, 5'd30, 5'd30, 5'd30, 5'd30, 5'd29,
        5'd29, 5'd30, 5'd31, 5'd31, 5'd31, 5'd30, 5'd29,
        5'd30, 5'd30, 5'd31, 5'd31, 5'd31, 5'd30, 5'd30,
        5'd29, 5'd30, 5'd31, 5'd31, 5'd31, 5'd30, 5'd29,
        5'd29, 5'd30, 5'd30, 5'd30, 5'd30, 5'd30, 5'd29,
        5'd28, 5'd29, 5'd29, 5'd30, 5'd29, 5'd29, 5'd28
    };

    // Legacy 9-point range curve.
    localparam logic [7:0] LEGACY_X [9] = '{
        8'd3, 8'd6, 8'd10, 8'd13, 8'd17, 8'd20, 8'd23, 8'd27, 8'd30
    };
    localparam logic [4:0] LEGACY_Y [9] = '{
        5'd30, 5'd26, 5'd19, 5'd13, 5'd7, 5'd4, 5'd2, 5'd1, 5'd0
    };

    // First register index of each region in the config address map.
    function automatic int weight_base();
        return 0;
    endfunction

    function automatic int x_base(input int ksize);
        return ksize * ksize;
    endfunction

    function automatic int y_base(input int ksize, input int pts);
        return ksize * ksize + pts;
    endfunction

    // Table lookups written as scans so every array index is a constant.
    function automatic int legacy_weight(input int idx);
        int w;
        w = 0;
        for (int k = 0; k < 49; k++)
            if (k == idx) w = int'(LEGACY_WEIGHTS[k]);
        return w;
    endfunction

    function automatic int legacy_x(input int idx);
        int v;
        v = 0;
        for (int k = 0; k < 9; k++)
            if (k == idx) v = int'(LEGACY_X[k]);
        return v;
    endfunction

    function automatic int legacy_y(input int idx);
        int v;
        v = 0;
        for (int k = 0; k < 9; k++)
            if (k == idx) v = int'(LEGACY_Y[k]);
        return v;
    endfunction

endpackage

// File: rtl/bnr_coef_default.sv
// Reset value of one coefficient register, selected by its config index.
// Reproduces the legacy tables for the 7x7 / 9-point geometry and falls back
// to a generic flat kernel with a linear curve otherwise.
module bnr_coef_default
    import bnr_cfg_pkg::*;
#(
    parameter int WEIGHT_BITS = 5,
    parameter int BITS        = 8,
    parameter int KSIZE       = 7,
    parameter int CURVE_PTS   = 9,
    parameter int IDX_W       = 7
)(
    input  logic [IDX_W-1:0] idx,
    output logic [BITS-1:0]  value
);

    localparam int  XB         = x_base(KSIZE);
    localparam int  YB         = y_base(KSIZE, CURVE_PTS);
    localparam bit  USE_LEGACY = (KSIZE == LEGACY_KSIZE) && (CURVE_PTS == LEGACY_PTS);
    localparam int  W_MAX      = (1 << WEIGHT_BITS) - 1;
    localparam int  X_SAT      = (1 << BITS) - 1;

    int idx_int;
    int dflt;

    // Weight and y values are clipped to WEIGHT_BITS so the stored upper bits stay zero.
    always_comb begin
        idx_int = int'(idx);
        dflt    = 0;
        if (idx_int < XB) begin
            dflt = USE_LEGACY ? (legacy_weight(idx_int - weight_base()) & W_MAX) : W_MAX;
        end else if (idx_int < YB) begin
            if (USE_LEGACY) begin
                dflt = legacy_x(idx_int - XB);
            end else begin
                dflt = 4 * (idx_int - XB + 1);
                if (dflt > X_SAT) dflt = X_SAT;
            end
        end else if (idx_int < YB + CURVE_PTS) begin
            if (USE_LEGACY) begin
                dflt = legacy_y(idx_int - YB) & W_MAX;
            end else begin
                dflt = W_MAX - 4 * (idx_int - YB);
                if (dflt < 0) dflt = 0;
            end
        end
        value = BITS'(dflt);
    end

endmodule

// File: rtl/bnr_coef_regbank.sv
// Double-buffered coefficient bank for the bilateral 2DNR filter. Software
// edits a shadow copy; an armed commit copies shadow to active on the next
// frame_start so the datapath never sees a mid-frame change.
// BITS must be >= WEIGHT_BITS; KSIZE odd 3..9; CURVE_PTS 2..16.
module bnr_coef_regbank
    import bnr_cfg_pkg::*;
#(
    parameter  int WEIGHT_BITS = 5,
    parameter  int BITS        = 8,
    parameter  int KSIZE       = 7,
    parameter  int CURVE_PTS   = 9,
    localparam int ADDR_W      = $clog2(KSIZE*KSIZE + 2*CURVE_PTS)
)(
    input  logic                               pclk,
    input  logic                               rst_n,
    input  logic                               cfg_wr_en,
    input  logic                               cfg_rd_en,
    input  logic [ADDR_W-1:0]                  cfg_addr,
    input  logic [BITS-1:0]                    cfg_wdata,
    output logic [BITS-1:0]                    cfg_rdata,
    output logic                               cfg_rvalid,
    input  logic                               cfg_commit,
    input  logic                               frame_start,
    output logic [KSIZE*KSIZE*WEIGHT_BITS-1:0] space_kernel,
    output logic [CURVE_PTS*BITS-1:0]          color_curve_x,
    output logic [CURVE_PTS*WEIGHT_BITS-1:0]   color_curve_y,
    output logic                               update_pending,
    output logic                               cfg_err
);

    localparam int NUM_REGS = KSIZE*KSIZE + 2*CURVE_PTS;
    localparam int WBASE    = weight_base();
    localparam int XB       = x_base(KSIZE);
    localparam int YB       = y_base(KSIZE, CURVE_PTS);
    localparam logic [BITS-1:0] WEIGHT_MASK = BITS'((1 << WEIGHT_BITS) - 1);

    logic [BITS-1:0] def_val     [NUM_REGS];
    logic [BITS-1:0] shadow_bank [NUM_REGS];
    logic [BITS-1:0] active_bank [NUM_REGS];

    bnr_state_t      state_reg;
    logic            update_pending_reg;
    logic            cfg_err_reg;
    logic            cfg_rvalid_reg;
    logic [BITS-1:0] cfg_rdata_reg;

    logic            addr_in_range;
    logic            rd_req;
    logic            swap;
    logic            shadow_valid;
    logic            cfg_err_next;
    logic [BITS-1:0] rdata_next;
    logic [CURVE_PTS-2:0] x_step_ok;

    assign addr_in_range = (cfg_addr <= ADDR_W'(NUM_REGS - 1));
    // A simultaneous write wins; the read strobe is dropped entirely.
    assign rd_req        = cfg_rd_en & ~cfg_wr_en;
    // The swap reads the pre-edge shadow, so a write in the same cycle lands in shadow only.
    assign swap          = (state_reg == ST_ARMED) & frame_start;
    assign cfg_err_next  = ((cfg_wr_en | rd_req) & ~addr_in_range)
                         | (cfg_commit & ~shadow_valid);

    genvar gi;

    // One shadow/active register pair per config index.
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam bit IS_X = (gi >= XB) && (gi < YB);
            localparam logic [BITS-1:0] WR_MASK = IS_X ? {BITS{1'b1}} : WEIGHT_MASK;

            logic [BITS-1:0] shadow_reg;
            logic [BITS-1:0] active_reg;

            bnr_coef_default #(
                .WEIGHT_BITS (WEIGHT_BITS),
                .BITS        (BITS),
                .KSIZE       (KSIZE),
                .CURVE_PTS   (CURVE_PTS),
                .IDX_W       (ADDR_W)
            ) u_default (
                .idx   (ADDR_W'(gi)),
                .value (def_val[gi])
            );

            // Shadow entry: software writes, weights and y keep only the low WEIGHT_BITS.
            always_ff @(posedge pclk or negedge rst_n) begin
                if (!rst_n)
                    shadow_reg <= def_val[gi];
                else if (cfg_wr_en && (cfg_addr == ADDR_W'(gi)))
                    shadow_reg <= cfg_wdata & WR_MASK;
            end

            // Active entry: only reloaded from shadow on an armed frame start.
            always_ff @(posedge pclk or negedge rst_n) begin
                if (!rst_n)
                    active_reg <= def_val[gi];
                else if (swap)
                    active_reg <= shadow_reg;
            end

            assign shadow_bank[gi] = shadow_reg;
            assign active_bank[gi] = active_reg;

            // Weight/y upper bits are held at zero by the write mask and never leave the block.
            if (!IS_X && (BITS > WEIGHT_BITS)) begin : g_hi
                logic unused_hi;
                assign unused_hi = |{active_reg[BITS-1:WEIGHT_BITS], def_val[gi][BITS-1:WEIGHT_BITS]};
            end
        end
    endgenerate

    // Spatial kernel, index r*KSIZE+c, entry 0 at the LSBs.
    generate
        for (gi = 0; gi < KSIZE*KSIZE; gi++) begin : g_kernel
            assign space_kernel[gi*WEIGHT_BITS +: WEIGHT_BITS] = active_bank[WBASE+gi][WEIGHT_BITS-1:0];
        end
    endgenerate

    // Range curve points, point 0 at the LSBs.
    generate
        for (gi = 0; gi < CURVE_PTS; gi++) begin : g_curve
            assign color_curve_x[gi*BITS +: BITS]               = active_bank[XB+gi];
            assign color_curve_y[gi*WEIGHT_BITS +: WEIGHT_BITS] = active_bank[YB+gi][WEIGHT_BITS-1:0];
        end
    endgenerate

    // Commit is only accepted when the shadow x points are strictly increasing.
    generate
        for (gi = 0; gi < CURVE_PTS-1; gi++) begin : g_mono
            assign x_step_ok[gi] = shadow_bank[XB+gi+1] > shadow_bank[XB+gi];
        end
    endgenerate
    assign shadow_valid = &x_step_ok;

    // Read mux over the shadow copy; unmapped addresses read as zero.
    always_comb begin
        rdata_next = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (cfg_addr == ADDR_W'(i)) rdata_next = shadow_bank[i];
    end

    // Registered read port: data and valid one cycle after the strobe.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_rvalid_reg <= 1'b0;
            cfg_rdata_reg  <= '0;
        end else begin
            cfg_rvalid_reg <= rd_req;
            if (rd_req) cfg_rdata_reg <= rdata_next;
        end
    end

    // Commit FSM with registered pending flag and error pulse.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= ST_IDLE;
            update_pending_reg <= 1'b0;
            cfg_err_reg        <= 1'b0;
        end else begin
            cfg_err_reg <= cfg_err_next;
            case (state_reg)
                ST_IDLE: begin
                    // A coincident frame_start is ignored here: the swap waits a full frame.
                    if (cfg_commit && shadow_valid) begin
                        state_reg          <= ST_ARMED;
                        update_pending_reg <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    // Further commits are absorbed; the swap takes whatever shadow holds.
                    if (frame_start) begin
                        state_reg          <= ST_IDLE;
                        update_pending_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg          <= ST_IDLE;
                    update_pending_reg <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_rdata      = cfg_rdata_reg;
    assign cfg_rvalid     = cfg_rvalid_reg;
    assign update_pending = update_pending_reg;
    assign cfg_err        = cfg_err_reg;

endmodule

// File: tb/tb_bnr_coef_regbank.sv
// Directed bench for bnr_coef_regbank at the legacy 7x7 / 9-point geometry.
module tb_bnr_coef_regbank;

    localparam int WB = 5;
    localparam int B  = 8;
    localparam int K  = 7;
    localparam int P  = 9;
    localparam int AW = 7;

    logic              pclk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_wr_en = 1'b0;
    logic              cfg_rd_en = 1'b0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [B-1:0]      cfg_wdata = '0;
    logic [B-1:0]      cfg_rdata;
    logic              cfg_rvalid;
    logic              cfg_commit = 1'b0;
    logic              frame_start = 1'b0;
    logic [K*K*WB-1:0] space_kernel;
    logic [P*B-1:0]    color_curve_x;
    logic [P*WB-1:0]   color_curve_y;
    logic              update_pending;
    logic              cfg_err;

    int errors = 0;
    int checks = 0;

    always #5 pclk = ~pclk;

    bnr_coef_regbank #(
        .WEIGHT_BITS (WB),
        .BITS        (B),
        .KSIZE       (K),
        .CURVE_PTS   (P)
    ) dut (
        .pclk           (pclk),
        .rst_n          (rst_n),
        .cfg_wr_en      (cfg_wr_en),
        .cfg_rd_en      (cfg_rd_en),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_rdata      (cfg_rdata),
        .cfg_rvalid     (cfg_rvalid),
        .cfg_commit     (cfg_commit),
        .frame_start    (frame_start),
        .space_kernel   (space_kernel),
        .color_curve_x  (color_curve_x),
        .color_curve_y  (color_curve_y),
        .update_pending (update_pending),
        .cfg_err        (cfg_err)
    );

    function automatic int kw(input int i);
        return int'(space_kernel[i*WB +: WB]);
    endfunction

    function automatic int cx(input int i);
        return int'(color_curve_x[i*B +: B]);
    endfunction

    function automatic int cy(input int i);
        return int'(color_curve_y[i*WB +: WB]);
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic write_reg(input int a, input int d);
        $display("txn write addr=%0d data=%0d", a, d);
        cfg_wr_en = 1'b1;
        cfg_addr  = AW'(a);
        cfg_wdata = B'(d);
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic read_reg(input int a);
        $display("txn read addr=%0d", a);
        cfg_rd_en = 1'b1;
        cfg_addr  = AW'(a);
        tick();
        cfg_rd_en = 1'b0;
    endtask

    task automatic pulse_commit();
        $display("txn commit");
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic pulse_frame();
        $display("txn frame_start");
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++; if (kw(24) !== 31) begin errors++; $display("FAIL reset_w33: got %0d expected 31", kw(24)); end
        checks++; if (kw(0) !== 28) begin errors++; $display("FAIL reset_w00: got %0d expected 28", kw(0)); end
        checks++; if (kw(3) !== 30) begin errors++; $display("FAIL reset_w03: got %0d expected 30", kw(3)); end
        checks++; if (kw(8) !== 30) begin errors++; $display("FAIL reset_w11: got %0d expected 30", kw(8)); end
        checks++; if (kw(7) !== 29) begin errors++; $display("FAIL reset_w10: got %0d expected 29", kw(7)); end
        checks++; if (kw(48) !== 28) begin errors++; $display("FAIL reset_w66: got %0d expected 28", kw(48)); end
        checks++; if (cx(0) !== 3) begin errors++; $display("FAIL reset_x0: got %0d expected 3", cx(0)); end
        checks++; if (cx(8) !== 30) begin errors++; $display("FAIL reset_x8: got %0d expected 30", cx(8)); end
        checks++; if (cy(0) !== 30) begin errors++; $display("FAIL reset_y0: got %0d expected 30", cy(0)); end
        checks++; if (cy(2) !== 19) begin errors++; $display("FAIL reset_y2: got %0d expected 19", cy(2)); end
        checks++; if (update_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %0b expected 0", update_pending); end
        checks++; if (cfg_rvalid !== 1'b0 || cfg_rdata !== '0 || cfg_err !== 1'b0) begin
            errors++; $display("FAIL reset_port: rvalid=%0b rdata=%0d err=%0b expected 0/0/0", cfg_rvalid, cfg_rdata, cfg_err);
        end
    endtask

    task automatic test_commit_swap();
        int early_bad;
        early_bad = 0;
        write_reg(24, 5);
        checks++; if (kw(24) !== 31) begin errors++; $display("FAIL write_no_active: got %0d expected 31", kw(24)); end
        pulse_commit();
        checks++; if (update_pending !== 1'b1) begin errors++; $display("FAIL commit_pending: got %0b expected 1", update_pending); end
        for (int i = 0; i < 9; i++) begin
            tick();
            if (kw(24) !== 31 || update_pending !== 1'b1) early_bad++;
        end
        checks++; if (early_bad != 0) begin errors++; $display("FAIL armed_hold: %0d cycles changed, expected 0", early_bad); end
        pulse_frame();
        checks++; if (kw(24) !== 5) begin errors++; $display("FAIL swap_w33: got %0d expected 5", kw(24)); end
        checks++; if (update_pending !== 1'b0) begin errors++; $display("FAIL swap_pending: got %0b expected 0", update_pending); end
        checks++; if (kw(0) !== 28) begin errors++; $display("FAIL swap_w00: got %0d expected 28", kw(0)); end
    endtask

    task automatic test_shadow_only();
        write_reg(24, 9);
        write_reg(0, 7);
        pulse_frame(); tick(); pulse_frame(); tick(); pulse_frame();
        checks++; if (kw(24) !== 5) begin errors++; $display("FAIL shadow_w33: got %0d expected 5", kw(24)); end
        checks++; if (kw(0) !== 28) begin errors++; $display("FAIL shadow_w00: got %0d expected 28", kw(0)); end
        cfg_rd_en = 1'b1;
        cfg_addr  = AW'(24);
        $display("txn read addr=24");
        checks++; if (cfg_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_early: got %0b expected 0", cfg_rvalid); end
        tick();
        cfg_rd_en = 1'b0;
        checks++; if (cfg_rvalid !== 1'b1 || cfg_rdata !== 8'd9) begin
            errors++; $display("FAIL read_w33: rvalid=%0b rdata=%0d expected 1/9", cfg_rvalid, cfg_rdata);
        end
        tick();
        checks++; if (cfg_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse: got %0b expected 0", cfg_rvalid); end
    endtask

    task automatic test_bad_commit();
        write_reg(53, 5);
        pulse_commit();
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL badcommit_err: got %0b expected 1", cfg_err); end
        checks++; if (update_pending !== 1'b0) begin errors++; $display("FAIL badcommit_pending: got %0b expected 0", update_pending); end
        tick();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL badcommit_errpulse: got %0b expected 0", cfg_err); end
        pulse_frame();
        checks++; if (cx(4) !== 17 || kw(24) !== 5) begin
            errors++; $display("FAIL badcommit_active: x4=%0d w33=%0d expected 17/5", cx(4), kw(24));
        end
        write_reg(53, 17);
    endtask

    task automatic test_out_of_range();
        write_reg(67, 8'hAA);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %0b expected 1", cfg_err); end
        tick();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse: got %0b expected 0", cfg_err); end
        read_reg(67);
        checks++; if (cfg_rvalid !== 1'b1 || cfg_rdata !== 8'd0 || cfg_err !== 1'b1) begin
            errors++; $display("FAIL oor_read: rvalid=%0b rdata=%0d err=%0b expected 1/0/1", cfg_rvalid, cfg_rdata, cfg_err);
        end
        read_reg(49);
        checks++; if (cfg_rvalid !== 1'b1 || cfg_rdata !== 8'd3 || cfg_err !== 1'b0) begin
            errors++; $display("FAIL read_x0: rvalid=%0b rdata=%0d err=%0b expected 1/3/0", cfg_rvalid, cfg_rdata, cfg_err);
        end
        checks++; if (kw(24) !== 5 || cx(8) !== 30) begin
            errors++; $display("FAIL oor_active: w33=%0d x8=%0d expected 5/30", kw(24), cx(8));
        end
    endtask

    task automatic test_masking();
        write_reg(1, 8'hFF);
        read_reg(1);
        checks++; if (cfg_rdata !== 8'd31) begin errors++; $display("FAIL mask_weight: got %0d expected 31", cfg_rdata); end
        write_reg(57, 200);
        read_reg(57);
        checks++; if (cfg_rdata !== 8'd200) begin errors++; $display("FAIL x_fullwidth: got %0d expected 200", cfg_rdata); end
        write_reg(66, 8'h3E);
        read_reg(66);
        checks++; if (cfg_rdata !== 8'd30) begin errors++; $display("FAIL mask_y: got %0d expected 30", cfg_rdata); end
    endtask

    task automatic test_coincident();
        $display("txn commit+frame_start");
        cfg_commit  = 1'b1;
        frame_start = 1'b1;
        tick();
        cfg_commit  = 1'b0;
        frame_start = 1'b0;
        checks++; if (update_pending !== 1'b1) begin errors++; $display("FAIL coinc_pending: got %0b expected 1", update_pending); end
        checks++; if (kw(24) !== 5 || kw(1) !== 29) begin
            errors++; $display("FAIL coinc_noswap: w33=%0d w01=%0d expected 5/29", kw(24), kw(1));
        end
        tick(); tick(); tick();
        pulse_frame();
        checks++; if (kw(24) !== 9 || kw(0) !== 7 || kw(1) !== 31) begin
            errors++; $display("FAIL coinc_swap_w: w33=%0d w00=%0d w01=%0d expected 9/7/31", kw(24), kw(0), kw(1));
        end
        checks++; if (cx(8) !== 200 || cy(8) !== 30) begin
            errors++; $display("FAIL coinc_swap_curve: x8=%0d y8=%0d expected 200/30", cx(8), cy(8));
        end
        checks++; if (update_pending !== 1'b0) begin errors++; $display("FAIL coinc_cleared: got %0b expected 0", update_pending); end
    endtask

    task automatic test_back_to_back();
        write_reg(2, 20);
        pulse_commit();
        pulse_commit();
        checks++; if (update_pending !== 1'b1) begin errors++; $display("FAIL b2b_pending: got %0b expected 1", update_pending); end
        $display("txn write addr=2 data=21 with frame_start");
        cfg_wr_en   = 1'b1;
        cfg_addr    = AW'(2);
        cfg_wdata   = 8'd21;
        frame_start = 1'b1;
        tick();
        cfg_wr_en   = 1'b0;
        frame_start = 1'b0;
        checks++; if (kw(2) !== 20) begin errors++; $display("FAIL b2b_preswap: got %0d expected 20", kw(2)); end
        checks++; if (update_pending !== 1'b0) begin errors++; $display("FAIL b2b_cleared: got %0b expected 0", update_pending); end
        read_reg(2);
        checks++; if (cfg_rdata !== 8'd21) begin errors++; $display("FAIL b2b_shadow: got %0d expected 21", cfg_rdata); end
    endtask

    task automatic test_reset_armed();
        write_reg(24, 3);
        pulse_commit();
        checks++; if (update_pending !== 1'b1) begin errors++; $display("FAIL rstarm_pending: got %0b expected 1", update_pending); end
        #3;
        $display("txn async reset");
        rst_n = 1'b0;
        #1;
        checks++; if (update_pending !== 1'b0) begin errors++; $display("FAIL rstarm_cleared: got %0b expected 0", update_pending); end
        checks++; if (kw(24) !== 31 || kw(2) !== 29 || kw(0) !== 28 || cx(8) !== 30) begin
            errors++; $display("FAIL rstarm_defaults: w33=%0d w02=%0d w00=%0d x8=%0d expected 31/29/28/30", kw(24), kw(2), kw(0), cx(8));
        end
        tick();
        rst_n = 1'b1;
        tick();
        pulse_frame();
        checks++; if (kw(24) !== 31) begin errors++; $display("FAIL rstarm_noswap: got %0d expected 31", kw(24)); end
        read_reg(24);
        checks++; if (cfg_rdata !== 8'd31) begin errors++; $display("FAIL rstarm_shadow: got %0d expected 31", cfg_rdata); end
    endtask

    initial begin
        test_reset();
        test_commit_swap();
        test_shadow_only();
        test_bad_commit();
        test_out_of_range();
        test_masking();
        test_coincident();
        test_back_to_back();
        test_reset_armed();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
